// File: rtl/bcd_reg_bank.sv
// Eight-channel binary-to-BCD register bank feeding the 3-digit seven-segment mux.
// Each accepted write is converted serially by double-dabble and then committed to its channel.
module bcd_reg_bank #(
    parameter logic [11:0] BLANK_CODE    = 12'hAAA,
    parameter bit          LEADING_BLANK = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_valid,
    output logic        wr_ready,
    input  logic [2:0]  wr_addr,
    input  logic [9:0]  wr_data,
    output logic        done,
    output logic [7:0]  ovf,
    output logic [11:0] reg0,
    output logic [11:0] reg1,
    output logic [11:0] reg2,
    output logic [11:0] reg3,
    output logic [11:0] reg4,
    output logic [11:0] reg5,
    output logic [11:0] reg6,
    output logic [11:0] reg7
);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        COMMIT
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  iter_q, iter_d;
    logic [11:0] acc_q, acc_d;
    logic [9:0]  bin_q, bin_d;
    logic [2:0]  addr_q, addr_d;
    logic        big_q, big_d;
    logic        done_q, done_d;
    logic [7:0]  ovf_q, ovf_d;
    logic [11:0] regs_q [8];
    logic [11:0] regs_d [8];
    logic [11:0] adj;
    logic [21:0] shifted;

    function automatic logic [11:0] dabble_adj(input logic [11:0] a);
        logic [11:0] r;
        r = a;
        for (int n = 0; n < 3; n++) begin
            if (r[n*4 +: 4] >= 4'd5) begin
                r[n*4 +: 4] = r[n*4 +: 4] + 4'd3;
            end
        end
        return r;
    endfunction

    // Leading zeros become 4'hA so the display blanks them; units always shown.
    function automatic logic [11:0] fmt_bcd(input logic [11:0] b);
        logic [3:0] h, t, u;
        h = b[11:8];
        t = b[7:4];
        u = b[3:0];
        if (LEADING_BLANK && h == 4'd0) begin
            h = 4'hA;
            if (t == 4'd0) begin
                t = 4'hA;
            end
        end
        return {h, t, u};
    endfunction

    always_comb begin
        state_d = state_q;
        iter_d  = iter_q;
        acc_d   = acc_q;
        bin_d   = bin_q;
        addr_d  = addr_q;
        big_d   = big_q;
        done_d  = 1'b0;
        ovf_d   = ovf_q;
        regs_d  = regs_q;
        adj     = dabble_adj(acc_q);
        shifted = {adj, bin_q} << 1;

        case (state_q)
            IDLE: begin
                if (wr_valid) begin
                    addr_d  = wr_addr;
                    bin_d   = wr_data;
                    big_d   = (wr_data > 10'd999);
                    acc_d   = 12'd0;
                    iter_d  = 4'd0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                acc_d  = shifted[21:10];
                bin_d  = shifted[9:0];
                iter_d = iter_q + 4'd1;
                if (iter_q == 4'd9) begin
                    state_d = COMMIT;
                end
            end
            COMMIT: begin
                regs_d[addr_q] = big_q ? BLANK_CODE : fmt_bcd(acc_q);
                ovf_d[addr_q]  = big_q;
                done_d         = 1'b1;
                state_d        = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            done_q  <= 1'b0;
            ovf_q   <= 8'h00;
            for (int i = 0; i < 8; i++) begin
                regs_q[i] <= BLANK_CODE;
            end
        end else begin
            state_q <= state_d;
            done_q  <= done_d;
            ovf_q   <= ovf_d;
            regs_q  <= regs_d;
        end
    end

    // Conversion datapath needs no reset; it is fully reloaded on every accept.
    always_ff @(posedge clk) begin
        iter_q <= iter_d;
        acc_q  <= acc_d;
        bin_q  <= bin_d;
        addr_q <= addr_d;
        big_q  <= big_d;
    end

    assign wr_ready = (state_q == IDLE);
    assign done     = done_q;
    assign ovf      = ovf_q;
    assign reg0     = regs_q[0];
    assign reg1     = regs_q[1];
    assign reg2     = regs_q[2];
    assign reg3     = regs_q[3];
    assign reg4     = regs_q[4];
    assign reg5     = regs_q[5];
    assign reg6     = regs_q[6];
    assign reg7     = regs_q[7];

endmodule

// File: doc/bcd_reg_bank.md
Name: bcd_reg_bank

Overview:
- Eight-entry binary-to-BCD register bank that sits directly upstream of the 8-register, 3-digit seven-segment multiplexer.
- Accepts 10-bit binary values (0..999) with a channel address over a valid/ready handshake.
- Converts each value serially with double-dabble and holds the packed 3-digit BCD result per channel; reg0..reg7 drive the display's register inputs directly.
- Nibble codes other than 0-9 blank a digit downstream; this block uses that for leading-zero suppression and out-of-range marking.

Parameters:
- BLANK_CODE, 12'hAAA, value written for reset and for out-of-range inputs; every nibble must be a non-decimal code.
- LEADING_BLANK, 1, when 1 leading zero digits are replaced by 4'hA; the units digit is never blanked.

Ports:
- clk  input  1  system clock, all logic on posedge
- rst  input  1  synchronous active-high reset
- wr_valid  input  1  write request
- wr_ready  output  1  block can accept a write this cycle
- wr_addr  input  3  target channel 0..7
- wr_data  input  10  unsigned binary value
- done  output  1  one-cycle pulse when a result is committed
- ovf  output  8  per-channel flag: last committed write to that channel was >999
- reg0 .. reg7  output  12 each  packed BCD {hundreds, tens, units}

Behaviour:
- Single clock; synchronous active-high reset.
- Reset (synchronous, rst high at posedge): state=IDLE; wr_ready=1; done=0; ovf=8'h00; reg0..reg7=BLANK_CODE; any in-flight conversion is aborted with no commit and no done pulse.
- FSM states:
  - IDLE: wr_ready=1. On edge T with wr_valid&wr_ready, capture addr and data, clear the 12-bit BCD accumulator, set iter=0, go to SHIFT.
  - SHIFT: wr_ready=0. Each edge: add 3 to every accumulator nibble >=5, then shift {acc, bin} left by 1, iter+=1. After the 10th iteration (edge T+10) go to COMMIT.
  - COMMIT: wr_ready=0. At edge T+11, write the target register, update ovf[addr], pulse done high for the following cycle, return to IDLE. wr_ready is high again in the cycle after T+11.
- Latency: the written register is visible 11 edges after the accept edge. Throughput: one write per 12 cycles.
- Out of range: if captured data >999, COMMIT writes BLANK_CODE and sets ovf[addr]=1. Otherwise it writes the formatted BCD and clears ovf[addr]=0. The shift sequence still runs its full length, so latency does not depend on data.
- Leading blank (LEADING_BLANK=1):
  - hundreds==0 -> hundreds nibble=4'hA.
  - hundreds==0 and tens==0 -> tens nibble=4'hA.
  - Value 0 -> 12'hAA0.
- Handshake: wr_valid while wr_ready=0 is ignored, with no queueing; the source must hold wr_valid/addr/data until accepted. Inputs are sampled only on the accept edge; later changes do not affect the conversion.
- Only the addressed register and ovf bit change on commit; all other registers hold.
- done is low at all times except the single cycle after a commit edge.

Test Plan:
- Reset: assert rst for 2 cycles -> reg0..reg7=12'hAAA, ovf=0, done=0, wr_ready=1.
- Write addr=3, data=10'd742 -> wr_ready low for 11 cycles; reg3=12'h742 at T+11; done pulses once; other regs stay 12'hAAA.
- Leading blank with LEADING_BLANK=1:
  - data 5 to addr 0 -> reg0=12'hAA5.
  - data 40 to addr 1 -> reg1=12'hA40.
  - data 0 to addr 2 -> reg2=12'hAA0.
  - data 100 to addr 7 -> reg7=12'h100.
- Overflow: data 1000 to addr 4 -> reg4=12'hAAA, ovf[4]=1. Then data 999 to addr 4 -> reg4=12'h999, ovf[4]=0.
- Back-pressure: hold wr_valid with changing data during busy -> only the accepted value is committed; the next accept happens in the first IDLE cycle, 12 cycles after the previous accept.
- Reset mid-operation: rst at T+5 of a write of 321 to addr 6 -> reg6=12'hAAA, no done pulse, wr_ready=1 the cycle after reset.
